// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and sizes for the hazard controller
package hazard_pkg;
  localparam int REG_IDX_W     = 5;
  localparam int FETCH_LAT_MAX = 3;
  localparam int CNT_W         = $clog2(FETCH_LAT_MAX + 1);
  typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT, SQUASH} state_e;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating stall-cycle and redirect-event counters
// Ports: clk_i/rst_ni clock and async active-low reset; stall_i counts cycles,
// flush_ev_i counts redirect events; stall_cnt_o/flush_cnt_o are 32-bit totals.
module hazard_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        flush_ev_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);
  logic [31:0] stall_q, stall_d, flush_q, flush_d;
  always_comb begin
    stall_d = (stall_i && ~&stall_q) ? stall_q + 32'd1 : stall_q;
    flush_d = (flush_ev_i && ~&flush_q) ? flush_q + 32'd1 : flush_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for load-use, redirect and data-memory wait
// Ports: clk_i, rst_ni (async active-low); ID source indices/uses, EX load/rd/redirect,
// dmem_busy_i in; PC/IF-ID stall, IF-ID/ID-EX flush, EX-MEM stall, MEM-WB bubble out.
// Define HAZARD_PERF_EN to add perf_stall_cnt_o and perf_flush_cnt_o.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FETCH_LAT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_rs1_used_i,
  input  logic                 id_rs2_used_i,
  input  logic                 ex_memread_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic                 ex_redirect_i,
  input  logic                 dmem_busy_i,
  output logic                 pc_stall_o,
  output logic                 if_id_stall_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_flush_o,
  output logic                 ex_mem_stall_o,
  output logic                 mem_wb_flush_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt_o,
  output logic [31:0]          perf_flush_cnt_o
`endif
);
  state_e state_q, state_d, saved_q, saved_d, eff;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic lu;
  assign lu = ex_memread_i && ex_rd_i != '0 &&
              ((id_rs1_used_i && id_rs1_i == ex_rd_i) || (id_rs2_used_i && id_rs2_i == ex_rd_i));
  // While waiting on memory, the frozen state is acted on as soon as busy drops.
  always_comb begin
    eff            = state_q == MEM_WAIT ? saved_q : state_q;
    state_d        = state_q;
    saved_d        = saved_q;
    cnt_d          = cnt_q;
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    if (!rst_ni) begin
      state_d = RUN;
    end else if (dmem_busy_i) begin
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      ex_mem_stall_o = 1'b1;
      mem_wb_flush_o = 1'b1;
      state_d        = MEM_WAIT;
      saved_d        = eff;
    end else if (ex_redirect_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      cnt_d         = CNT_W'(FETCH_LAT);
      state_d       = SQUASH;
    end else if (eff == SQUASH) begin
      if_id_flush_o = cnt_q != '0;
      cnt_d         = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
      state_d       = cnt_d == '0 ? RUN : SQUASH;
    end else if (eff == RUN && lu) begin
      pc_stall_o    = 1'b1;
      if_id_stall_o = 1'b1;
      id_ex_flush_o = 1'b1;
      state_d       = LU_BUBBLE;
    end else begin
      state_d = RUN;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_perf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .stall_i     (pc_stall_o),
    .flush_ev_i  (ex_redirect_i && !dmem_busy_i),
    .stall_cnt_o (perf_stall_cnt_o),
    .flush_cnt_o (perf_flush_cnt_o)
  );
`endif
endmodule
